// File: rtl/fuel_pkg.sv
`default_nettype none
// ============================================================================
// Module : fuel_pkg
// Brief  : Shared channel state encoding and default sizing for the
//          multi-nozzle price engine.
// Rev    : 1.0  initial release
// ============================================================================
package fuel_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUMP = 2'd1,
        DONE = 2'd2
    } ch_state_t;

    localparam int DEF_PRICE_W     = 17;
    localparam int DEF_VOL_W       = 16;
    localparam int DEF_TICK_CYCLES = 1704545;

    localparam logic [16:0] DEFAULT_UNIT_PRICE = 17'd1000;

endpackage
`default_nettype wire

// File: rtl/pump_channel.sv
`default_nettype none
// ============================================================================
// Module : pump_channel
// Brief  : One nozzle: IDLE/PUMP/DONE FSM, metering prescaler, price and
//          volume accumulators with preset cut-off and saturation.
// Rev    : 1.0  initial release
// ============================================================================
module pump_channel
    import fuel_pkg::*;
#(
    parameter int PRICE_W     = DEF_PRICE_W,
    parameter int VOL_W       = DEF_VOL_W,
    parameter int TICK_CYCLES = DEF_TICK_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               start,
    input  logic               stop,
    input  logic               preset_en,
    input  logic [PRICE_W-1:0] preset_price,
    input  logic [PRICE_W-1:0] unit_price,
    output logic               relay,
    output logic [PRICE_W-1:0] price,
    output logic [VOL_W-1:0]   volume,
    output logic               done,
    output logic               sat
);

    localparam int PS_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PS_W-1:0] C_TICK_LAST = PS_W'(TICK_CYCLES - 1);

    ch_state_t          r_state, w_state;
    logic [PS_W-1:0]    r_ps, w_ps;
    logic [PRICE_W-1:0] r_price, w_price;
    logic [VOL_W-1:0]   r_vol, w_vol;
    logic               r_sat, w_sat;
    logic [PRICE_W-1:0] r_step, w_step;
    logic [PRICE_W-1:0] r_target, w_target;
    logic               r_pen, w_pen;

    logic               w_tick;
    logic               w_vol_inc;
    logic [PRICE_W:0]   w_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ps     <= '0;
            r_price  <= '0;
            r_vol    <= '0;
            r_sat    <= 1'b0;
            r_step   <= '0;
            r_target <= '0;
            r_pen    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_ps     <= w_ps;
            r_price  <= w_price;
            r_vol    <= w_vol;
            r_sat    <= w_sat;
            r_step   <= w_step;
            r_target <= w_target;
            r_pen    <= w_pen;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_ps      = r_ps;
        w_price   = r_price;
        w_vol     = r_vol;
        w_sat     = r_sat;
        w_step    = r_step;
        w_target  = r_target;
        w_pen     = r_pen;
        w_vol_inc = 1'b0;
        w_nxt     = {1'b0, r_price} + {1'b0, r_step};
        w_tick    = (r_state == PUMP) && (r_ps == C_TICK_LAST);

        if (clear) begin
            w_state = IDLE;
            w_price = '0;
            w_vol   = '0;
            w_sat   = 1'b0;
            w_ps    = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // a zero preset would end the sale before it begins
                    if (!stop && start && !(preset_en && (preset_price == '0))) begin
                        w_step   = unit_price;
                        w_target = preset_price;
                        w_pen    = preset_en;
                        w_ps     = '0;
                        w_state  = PUMP;
                    end
                end
                PUMP: begin
                    if (stop) begin
                        w_state = DONE;
                    end else begin
                        w_ps = w_tick ? '0 : r_ps + PS_W'(1);
                        if (w_tick) begin
                            if (r_pen && (w_nxt >= {1'b0, r_target})) begin
                                w_price   = r_target;
                                w_vol_inc = 1'b1;
                                w_state   = DONE;
                            end else if (w_nxt[PRICE_W]) begin
                                w_price = '1;
                                w_sat   = 1'b1;
                                w_state = DONE;
                            end else begin
                                w_price   = w_nxt[PRICE_W-1:0];
                                w_vol_inc = 1'b1;
                            end
                            if (r_vol == '1) begin
                                w_sat   = 1'b1;
                                w_state = DONE;
                            end else if (w_vol_inc) begin
                                w_vol = r_vol + VOL_W'(1);
                            end
                        end
                    end
                end
                DONE:    w_state = DONE;
                default: w_state = IDLE;
            endcase
        end
    end

    assign relay  = (r_state == PUMP);
    assign done   = (r_state == DONE);
    assign price  = r_price;
    assign volume = r_vol;
    assign sat    = r_sat;

endmodule
`default_nettype wire

// File: rtl/multi_nozzle_price_engine.sv
`default_nettype none
// ============================================================================
// Module : multi_nozzle_price_engine
// Brief  : N_CH independent nozzle meters; slices the packed buses per channel.
// Rev    : 1.0  initial release
// ============================================================================
module multi_nozzle_price_engine
    import fuel_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int PRICE_W     = DEF_PRICE_W,
    parameter int VOL_W       = DEF_VOL_W,
    parameter int TICK_CYCLES = DEF_TICK_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         clear,
    input  logic [N_CH-1:0]         start,
    input  logic [N_CH-1:0]         stop,
    input  logic [N_CH-1:0]         preset_en,
    input  logic [N_CH*PRICE_W-1:0] preset_price,
    input  logic [PRICE_W-1:0]      unit_price,
    output logic [N_CH-1:0]         relay,
    output logic [N_CH*PRICE_W-1:0] price,
    output logic [N_CH*VOL_W-1:0]   volume,
    output logic [N_CH-1:0]         done,
    output logic [N_CH-1:0]         sat
);

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            pump_channel #(
                .PRICE_W     (PRICE_W),
                .VOL_W       (VOL_W),
                .TICK_CYCLES (TICK_CYCLES)
            ) u_ch (
                .clk          (clk),
                .rst          (rst),
                .clear        (clear[i]),
                .start        (start[i]),
                .stop         (stop[i]),
                .preset_en    (preset_en[i]),
                .preset_price (preset_price[i*PRICE_W +: PRICE_W]),
                .unit_price   (unit_price),
                .relay        (relay[i]),
                .price        (price[i*PRICE_W +: PRICE_W]),
                .volume       (volume[i*VOL_W +: VOL_W]),
                .done         (done[i]),
                .sat          (sat[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_multi_nozzle_price_engine.sv
`default_nettype none
// ============================================================================
// Module : tb_multi_nozzle_price_engine
// Brief  : Directed vector table, hand sequences and randomized traffic
//          against a behavioural per-nozzle model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_multi_nozzle_price_engine;

    localparam int N_CH = 2;
    localparam int PW   = 17;
    localparam int VW   = 5;
    localparam int TICK = 4;
    localparam longint PMAX = (64'd1 << PW) - 1;
    localparam longint VMAX = (64'd1 << VW) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [N_CH-1:0]    clear = '0, start = '0, stop = '0, pen = '0;
    logic [N_CH*PW-1:0] preset = '0;
    logic [PW-1:0]      unit = '0;
    logic [N_CH-1:0]    relay, done, sat;
    logic [N_CH*PW-1:0] price;
    logic [N_CH*VW-1:0] volume;

    multi_nozzle_price_engine #(
        .N_CH(N_CH), .PRICE_W(PW), .VOL_W(VW), .TICK_CYCLES(TICK)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear), .start(start), .stop(stop),
        .preset_en(pen), .preset_price(preset), .unit_price(unit),
        .relay(relay), .price(price), .volume(volume), .done(done), .sat(sat)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // behavioural model: 0 idle, 1 pumping, 2 finished
    int     m_mode[N_CH];
    longint m_price[N_CH], m_vol[N_CH], m_step[N_CH], m_target[N_CH];
    int     m_elapsed[N_CH];
    bit     m_sat[N_CH], m_pen[N_CH];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_mode[c] = 0; m_price[c] = 0; m_vol[c] = 0; m_step[c] = 0;
            m_target[c] = 0; m_elapsed[c] = 0; m_sat[c] = 0; m_pen[c] = 0;
        end
    endtask

    task automatic model_edge(input int c);
        longint sum;
        bit inc;
        longint pre;
        pre = preset[c*PW +: PW];
        if (clear[c]) begin
            m_mode[c] = 0; m_price[c] = 0; m_vol[c] = 0; m_sat[c] = 0;
        end else if (m_mode[c] == 0) begin
            if (!stop[c] && start[c] && !(pen[c] && pre == 0)) begin
                m_mode[c] = 1; m_step[c] = unit; m_target[c] = pre;
                m_pen[c] = pen[c]; m_elapsed[c] = 0;
            end
        end else if (m_mode[c] == 1) begin
            if (stop[c]) begin
                m_mode[c] = 2;
            end else begin
                m_elapsed[c]++;
                if (m_elapsed[c] % TICK == 0) begin
                    sum = m_price[c] + m_step[c];
                    inc = 1;
                    if (m_pen[c] && sum >= m_target[c]) begin
                        m_price[c] = m_target[c]; m_mode[c] = 2;
                    end else if (sum > PMAX) begin
                        m_price[c] = PMAX; m_sat[c] = 1; m_mode[c] = 2; inc = 0;
                    end else begin
                        m_price[c] = sum;
                    end
                    if (m_vol[c] == VMAX) begin
                        m_sat[c] = 1; m_mode[c] = 2;
                    end else if (inc) begin
                        m_vol[c]++;
                    end
                end
            end
        end
    endtask

    task automatic check_model();
        for (int c = 0; c < N_CH; c++) begin
            chk($sformatf("ch%0d relay", c),  relay[c], m_mode[c] == 1);
            chk($sformatf("ch%0d done", c),   done[c],  m_mode[c] == 2);
            chk($sformatf("ch%0d sat", c),    sat[c],   m_sat[c]);
            chk($sformatf("ch%0d price", c),  price[c*PW +: PW], m_price[c]);
            chk($sformatf("ch%0d volume", c), volume[c*VW +: VW], m_vol[c]);
        end
    endtask

    task automatic cycle();
        for (int c = 0; c < N_CH; c++) model_edge(c);
        @(posedge clk);
        #1;
        check_model();
    endtask

    typedef struct {
        bit clr, st, sp, pe;
        logic [PW-1:0] pre, up;
        int cycles;
        bit e_relay, e_done, e_sat;
        longint e_price, e_vol;
    } vec_t;

    vec_t tbl[30];

    function automatic vec_t v(bit clr, bit st, bit sp, bit pe, int pre, int up, int cyc,
                               bit er, longint ep, longint ev, bit ed, bit es);
        vec_t r;
        r.clr = clr; r.st = st; r.sp = sp; r.pe = pe;
        r.pre = PW'(pre); r.up = PW'(up); r.cycles = cyc;
        r.e_relay = er; r.e_price = ep; r.e_vol = ev; r.e_done = ed; r.e_sat = es;
        return r;
    endfunction

    initial begin
        //          clr st sp pe  pre   unit  cyc  rly price  vol done sat
        tbl[0]  = v(1, 0, 0, 0,    0,     0,   1,  0,      0,  0, 0, 0);
        tbl[1]  = v(0, 1, 0, 0,    0,  1000,   1,  1,      0,  0, 0, 0);
        tbl[2]  = v(0, 0, 0, 0,    0,  1000,   4,  1,   1000,  1, 0, 0);
        tbl[3]  = v(0, 0, 0, 0,    0,  1000,   4,  1,   2000,  2, 0, 0);
        tbl[4]  = v(0, 0, 0, 0,    0,  1000,   4,  1,   3000,  3, 0, 0);
        tbl[5]  = v(0, 0, 1, 0,    0,  1000,   1,  0,   3000,  3, 1, 0);
        tbl[6]  = v(0, 1, 0, 0,    0,  1000,   2,  0,   3000,  3, 1, 0);
        tbl[7]  = v(1, 1, 0, 0,    0,  1000,   1,  0,      0,  0, 0, 0);
        tbl[8]  = v(0, 1, 0, 1, 2500,  1000,   1,  1,      0,  0, 0, 0);
        tbl[9]  = v(0, 0, 0, 1, 2500,  1000,   4,  1,   1000,  1, 0, 0);
        tbl[10] = v(0, 0, 0, 1, 2500,  1000,   4,  1,   2000,  2, 0, 0);
        tbl[11] = v(0, 0, 0, 1, 2500,  1000,   3,  1,   2000,  2, 0, 0);
        tbl[12] = v(0, 0, 0, 1, 2500,  1000,   1,  0,   2500,  3, 1, 0);
        tbl[13] = v(1, 0, 0, 0,    0,  1000,   1,  0,      0,  0, 0, 0);
        tbl[14] = v(0, 1, 0, 0,    0, 60000,   1,  1,      0,  0, 0, 0);
        tbl[15] = v(0, 0, 0, 0,    0, 60000,   4,  1,  60000,  1, 0, 0);
        tbl[16] = v(0, 0, 0, 0,    0, 60000,   4,  1, 120000,  2, 0, 0);
        tbl[17] = v(0, 0, 0, 0,    0, 60000,   4,  0, 131071,  2, 1, 1);
        tbl[18] = v(1, 0, 0, 0,    0,  1000,   1,  0,      0,  0, 0, 0);
        tbl[19] = v(0, 1, 0, 0,    0,  1000,   1,  1,      0,  0, 0, 0);
        tbl[20] = v(0, 0, 0, 0,    0,  1000,   4,  1,   1000,  1, 0, 0);
        tbl[21] = v(0, 0, 0, 0,    0,  1000,   3,  1,   1000,  1, 0, 0);
        tbl[22] = v(0, 0, 1, 0,    0,  1000,   1,  0,   1000,  1, 1, 0);
        tbl[23] = v(1, 0, 0, 0,    0,  1000,   1,  0,      0,  0, 0, 0);
        tbl[24] = v(0, 1, 0, 1,    0,  1000,   1,  0,      0,  0, 0, 0);
        tbl[25] = v(0, 0, 0, 1,    0,  1000,   3,  0,      0,  0, 0, 0);
        tbl[26] = v(0, 1, 0, 0,    0,     0,   1,  1,      0,  0, 0, 0);
        tbl[27] = v(0, 0, 0, 0,    0,     0, 124,  1,      0, 31, 0, 0);
        tbl[28] = v(0, 0, 0, 0,    0,     0,   4,  0,      0, 31, 1, 1);
        tbl[29] = v(1, 0, 0, 0,    0,     0,   1,  0,      0,  0, 0, 0);

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset relay", relay, 0);
        chk("reset done", done, 0);
        chk("reset sat", sat, 0);
        chk("reset price", price, 0);
        chk("reset volume", volume, 0);
        rst = 1'b0;

        // directed table on channel 0
        for (int i = 0; i < 30; i++) begin
            clear[0] = tbl[i].clr; start[0] = tbl[i].st; stop[0] = tbl[i].sp;
            pen[0] = tbl[i].pe; preset[0 +: PW] = tbl[i].pre; unit = tbl[i].up;
            cycle();
            clear[0] = 1'b0; start[0] = 1'b0; stop[0] = 1'b0;
            for (int k = 1; k < tbl[i].cycles; k++) cycle();
            chk($sformatf("vec%0d relay", i),  relay[0], tbl[i].e_relay);
            chk($sformatf("vec%0d done", i),   done[0],  tbl[i].e_done);
            chk($sformatf("vec%0d sat", i),    sat[0],   tbl[i].e_sat);
            chk($sformatf("vec%0d price", i),  price[0 +: PW], tbl[i].e_price);
            chk($sformatf("vec%0d volume", i), volume[0 +: VW], tbl[i].e_vol);
        end

        // asynchronous reset in the middle of a sale
        pen = '0; unit = 17'd500; start[0] = 1'b1;
        cycle();
        start[0] = 1'b0;
        repeat (6) cycle();
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async rst relay0", relay[0], 0);
        chk("async rst all outputs", {relay, done, sat, price, volume} == '0, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_model();

        // independent channels, shared unit price sampled at each start
        unit = 17'd700; start[0] = 1'b1;
        cycle();
        start[0] = 1'b0;
        cycle();
        unit = 17'd1300; start[1] = 1'b1;
        cycle();
        start[1] = 1'b0;
        repeat (10) cycle();
        clear[1] = 1'b1;
        cycle();
        clear[1] = 1'b0;
        chk("indep ch1 price cleared", price[PW +: PW], 0);
        chk("indep ch1 volume cleared", volume[VW +: VW], 0);
        chk("indep ch0 still pumping", relay[0], 1);
        repeat (10) cycle();
        chk("indep ch0 price", price[0 +: PW], 700 * 5);
        clear = '1;
        cycle();
        clear = '0;

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < N_CH; c++) begin
                clear[c] = ($urandom % 64) == 0;
                start[c] = ($urandom % 6) == 0;
                stop[c]  = ($urandom % 48) == 0;
                if (($urandom % 8) == 0) pen[c] = $urandom % 2;
                if (($urandom % 8) == 0)
                    preset[c*PW +: PW] = (($urandom % 4) == 0) ? '0 : PW'($urandom_range(1, 20000));
            end
            if (($urandom % 4) == 0) begin
                case ($urandom % 3)
                    0:       unit = '0;
                    1:       unit = PW'($urandom_range(50000, 131071));
                    default: unit = PW'($urandom_range(1, 5000));
                endcase
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
